// File: rtl/serial_mem_responder.sv
// ---------------------------------------------------------------------------
// serial_mem_responder
//
// Memory side of the byte-serial CPU bus. Answers instruction fetches from an
// internal instruction RAM and word loads/stores against an internal data
// RAM, so the core can run without an external microcontroller.
//
// Ports
//   clk               system clock
//   rst               synchronous, active-high reset
//   out_bus[7:0]      byte from core (address/data, low byte first)
//   bus_pc            core presents PC low byte (fetch request)
//   bus_mar           core presents address low byte (load/store request)
//   bus_mdr           sampled with bus_mar: 1 = store, 0 = load
//   in_bus[7:0]       response byte to core
//   ard_data_ready    in_bus valid this cycle
//   ard_receive_ready responder idle and accepting a request
//   protocol_err      sticky protocol-violation flag (cleared by rst only)
//   dbg_addr[15:0]    debug data-RAM read address
//   dbg_data[15:0]    data RAM[dbg_addr mod DMEM_DEPTH], combinational
//   txn_count[15:0]   completed-transaction counter, present only when
//                     SERIAL_MEM_TXN_COUNT_EN is defined
//
// Optional feature macro: SERIAL_MEM_TXN_COUNT_EN
// ---------------------------------------------------------------------------
module serial_mem_responder #(
    parameter int                IMEM_DEPTH  = 256,
    parameter int                DMEM_DEPTH  = 256,
    parameter int                TYPE_W      = 3,
    parameter logic [TYPE_W-1:0] R_TYPE_CODE = '0,
    parameter string             IMEM_INIT   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  out_bus,
    input  logic        bus_pc,
    input  logic        bus_mar,
    input  logic        bus_mdr,
    output logic [7:0]  in_bus,
    output logic        ard_data_ready,
    output logic        ard_receive_ready,
    output logic        protocol_err,
`ifdef SERIAL_MEM_TXN_COUNT_EN
    output logic [15:0] txn_count,
`endif
    input  logic [15:0] dbg_addr,
    output logic [15:0] dbg_data
);

    localparam int IW = $clog2(IMEM_DEPTH);
    localparam int DW = $clog2(DMEM_DEPTH);

    typedef enum logic [3:0] {
        IDLE, PC_HI, I_RD, I_LO, I_HI, X_LO, X_HI,
        A_HI, S_LO, S_HI, D_RD, D_LO, D_HI
    } state_t;

    logic [15:0] imem_q [IMEM_DEPTH];
    logic [15:0] dmem_q [DMEM_DEPTH];

    state_t      state_q;
    logic [7:0]  in_bus_q;
    logic        drdy_q;
    logic        rrdy_q;
    logic        perr_q;

    // Shared address register: PC for fetches, data address for loads/stores.
    logic [15:0] a_q;
    logic        store_q;
    logic [7:0]  dlo_q;
    logic [15:0] instr_q;
    // Second response word: PC+1 word on fetches, read data on loads.
    logic [15:0] xword_q;

    logic [IW-1:0] pc_idx;
    logic [IW-1:0] pc1_idx;
    logic [DW-1:0] d_idx;
    logic [DW-1:0] dbg_idx;
    logic [15:0]   imem_rd;
    logic [15:0]   dmem_rd;
    logic          is_r;
    logic          open_state;
    logic          bad_req;

    // Power-of-two depths make the modulo a plain bit truncation.
    assign pc_idx  = IW'(a_q % IMEM_DEPTH);
    assign pc1_idx = pc_idx + IW'(1);
    assign d_idx   = DW'(a_q % DMEM_DEPTH);
    assign dbg_idx = DW'(dbg_addr % DMEM_DEPTH);

    assign imem_rd  = imem_q[pc_idx];
    assign dmem_rd  = dmem_q[d_idx];
    assign dbg_data = dmem_q[dbg_idx];

    assign is_r = (instr_q[TYPE_W-1:0] == R_TYPE_CODE);

    // Request strobes are legal only while a request is being presented.
    assign open_state = (state_q == IDLE) || (state_q == PC_HI) || (state_q == A_HI);
    assign bad_req    = ((state_q == IDLE) && bus_pc && bus_mar) ||
                        (!open_state && (bus_pc || bus_mar));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            in_bus_q <= 8'h00;
            drdy_q   <= 1'b0;
            rrdy_q   <= 1'b1;
            perr_q   <= 1'b0;
        end else begin
            if (bad_req) perr_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    // Fetch wins when both strobes arrive together.
                    if (bus_pc) begin
                        a_q[7:0] <= out_bus;
                        rrdy_q   <= 1'b0;
                        state_q  <= PC_HI;
                    end else if (bus_mar) begin
                        a_q[7:0] <= out_bus;
                        store_q  <= bus_mdr;
                        rrdy_q   <= 1'b0;
                        state_q  <= A_HI;
                    end
                end
                PC_HI: begin
                    a_q[15:8] <= out_bus;
                    state_q   <= I_RD;
                end
                I_RD: begin
                    instr_q  <= imem_rd;
                    xword_q  <= imem_q[pc1_idx];
                    in_bus_q <= imem_rd[7:0];
                    drdy_q   <= 1'b1;
                    state_q  <= I_LO;
                end
                I_LO: begin
                    in_bus_q <= instr_q[15:8];
                    state_q  <= I_HI;
                end
                I_HI: begin
                    if (is_r) begin
                        drdy_q  <= 1'b0;
                        rrdy_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        in_bus_q <= xword_q[7:0];
                        state_q  <= X_LO;
                    end
                end
                X_LO: begin
                    in_bus_q <= xword_q[15:8];
                    state_q  <= X_HI;
                end
                A_HI: begin
                    a_q[15:8] <= out_bus;
                    state_q   <= store_q ? S_LO : D_RD;
                end
                S_LO: begin
                    dlo_q   <= out_bus;
                    state_q <= S_HI;
                end
                S_HI: begin
                    // Write lands here, so a following load already sees it.
                    dmem_q[d_idx] <= {out_bus, dlo_q};
                    rrdy_q        <= 1'b1;
                    state_q       <= IDLE;
                end
                D_RD: begin
                    xword_q  <= dmem_rd;
                    in_bus_q <= dmem_rd[7:0];
                    drdy_q   <= 1'b1;
                    state_q  <= D_LO;
                end
                D_LO: begin
                    in_bus_q <= xword_q[15:8];
                    state_q  <= D_HI;
                end
                X_HI, D_HI: begin
                    drdy_q  <= 1'b0;
                    rrdy_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    drdy_q  <= 1'b0;
                    rrdy_q  <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Handshake outputs read as idle/quiet during the reset cycle itself.
    assign in_bus            = rst ? 8'h00 : in_bus_q;
    assign ard_data_ready    = drdy_q & ~rst;
    assign ard_receive_ready = rrdy_q & ~rst;
    assign protocol_err      = perr_q;

`ifdef SERIAL_MEM_TXN_COUNT_EN
    logic [15:0] txn_q;
    logic [15:0] txn_d;
    logic        txn_done;

    // A transaction completes on its last response byte or its write cycle.
    assign txn_done = ((state_q == I_HI) && is_r) || (state_q == X_HI) ||
                      (state_q == D_HI) || (state_q == S_HI);
    assign txn_d    = txn_q + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            txn_q <= 16'd0;
        end else if (txn_done) begin
            txn_q <= txn_d;
        end
    end

    assign txn_count = txn_q;
`endif

endmodule

// File: tb/tb_serial_mem_responder.sv
module tb_serial_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  out_bus;
    logic        bus_pc;
    logic        bus_mar;
    logic        bus_mdr;
    logic [7:0]  in_bus;
    logic        ard_data_ready;
    logic        ard_receive_ready;
    logic        protocol_err;
    logic [15:0] dbg_addr;
    logic [15:0] dbg_data;
`ifdef SERIAL_MEM_TXN_COUNT_EN
    logic [15:0] txn_count;
`endif

    int checks = 0;
    int errors = 0;

    serial_mem_responder dut (
        .clk               (clk),
        .rst               (rst),
        .out_bus           (out_bus),
        .bus_pc            (bus_pc),
        .bus_mar           (bus_mar),
        .bus_mdr           (bus_mdr),
        .in_bus            (in_bus),
        .ard_data_ready    (ard_data_ready),
        .ard_receive_ready (ard_receive_ready),
        .protocol_err      (protocol_err),
`ifdef SERIAL_MEM_TXN_COUNT_EN
        .txn_count         (txn_count),
`endif
        .dbg_addr          (dbg_addr),
        .dbg_data          (dbg_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] pc;
        logic [15:0] w0;
        logic [15:0] w1;
        int          n;
        logic [31:0] exp;
    } fvec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Collect response bytes until the responder is idle again (bounded).
    task automatic collect(input int pulse_at, output int n, output logic [31:0] rx);
        logic done;
        n    = 0;
        rx   = '0;
        done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            bus_mar = 1'b0;
            if (ard_receive_ready) begin
                done = 1'b1;
                break;
            end
            if (ard_data_ready) begin
                if (n < 4) rx[8*n +: 8] = in_bus;
                if (n == pulse_at) bus_mar = 1'b1;
                n++;
            end
        end
        chk("rx_back_to_idle", {31'b0, done}, 32'd1);
    endtask

    task automatic fetch(input logic [15:0] pc, input logic both, input int pulse_at,
                         output int n, output logic [31:0] rx);
        bus_pc  = 1'b1;
        bus_mar = both;
        bus_mdr = both;
        out_bus = pc[7:0];
        @(negedge clk);
        bus_pc  = 1'b0;
        bus_mar = 1'b0;
        bus_mdr = 1'b0;
        out_bus = pc[15:8];
        collect(pulse_at, n, rx);
    endtask

    task automatic store(input logic [15:0] addr, input logic [15:0] data);
        bus_mar = 1'b1;
        bus_mdr = 1'b1;
        out_bus = addr[7:0];
        @(negedge clk);
        bus_mar = 1'b0;
        bus_mdr = 1'b0;
        out_bus = addr[15:8];
        @(negedge clk);
        out_bus = data[7:0];
        @(negedge clk);
        out_bus = data[15:8];
        @(negedge clk);
        chk("store_idle", {31'b0, ard_receive_ready}, 32'd1);
    endtask

    task automatic load(input logic [15:0] addr, output int n, output logic [31:0] rx);
        bus_mar = 1'b1;
        bus_mdr = 1'b0;
        out_bus = addr[7:0];
        @(negedge clk);
        bus_mar = 1'b0;
        out_bus = addr[15:8];
        collect(-1, n, rx);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic dbg_chk(input string name, input logic [15:0] a, input logic [15:0] exp);
        dbg_addr = a;
        #1;
        chk(name, {16'b0, dbg_data}, {16'b0, exp});
    endtask

    initial begin
        fvec_t       tbl [4];
        int          n;
        logic [31:0] rx;
        logic [7:0]  idx0;
        logic [7:0]  idx1;
        logic [15:0] pc;
        logic [15:0] r1;
        logic [15:0] r2;
        logic [15:0] sw_addr;
        logic [15:0] exp_pc [4];
        int          exp_n [4];

        tbl[0] = '{pc: 16'h0010, w0: 16'h1230, w1: 16'h9999, n: 2, exp: 32'h0000_1230};
        tbl[1] = '{pc: 16'h0020, w0: 16'h5671, w1: 16'hBEEF, n: 4, exp: 32'hBEEF_5671};
        tbl[2] = '{pc: 16'h01FF, w0: 16'h0002, w1: 16'hCAFE, n: 4, exp: 32'hCAFE_0002};
        tbl[3] = '{pc: 16'h0030, w0: 16'hFFF8, w1: 16'h4444, n: 2, exp: 32'h0000_FFF8};
        exp_pc[0] = 16'd0; exp_pc[1] = 16'd2; exp_pc[2] = 16'd4; exp_pc[3] = 16'd5;
        exp_n[0] = 4; exp_n[1] = 4; exp_n[2] = 2; exp_n[3] = 4;

        rst = 1'b1; out_bus = 8'h00; bus_pc = 1'b0; bus_mar = 1'b0; bus_mdr = 1'b0;
        dbg_addr = 16'h0000;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_cycle_rrdy", {31'b0, ard_receive_ready}, 32'd0);
        chk("rst_cycle_drdy", {31'b0, ard_data_ready}, 32'd0);
        chk("rst_cycle_in_bus", {24'b0, in_bus}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_rrdy", {31'b0, ard_receive_ready}, 32'd1);
        chk("post_rst_drdy", {31'b0, ard_data_ready}, 32'd0);
        chk("post_rst_perr", {31'b0, protocol_err}, 32'd0);
        chk("post_rst_in_bus", {24'b0, in_bus}, 32'd0);
        @(negedge clk);

        // Raw fetches: R-type vs two-word, PC wrap and PC+1 wrap
        for (int i = 0; i < 4; i++) begin
            idx0 = tbl[i].pc[7:0];
            idx1 = idx0 + 8'd1;
            dut.imem_q[idx0] = tbl[i].w0;
            dut.imem_q[idx1] = tbl[i].w1;
            fetch(tbl[i].pc, 1'b0, -1, n, rx);
            chk($sformatf("fetch%0d_nbytes", i), n, tbl[i].n);
            chk($sformatf("fetch%0d_bytes", i), rx, tbl[i].exp);
        end
        chk("in_bus_hold", {24'b0, in_bus}, 32'h0000_00FF);
        chk("no_err_yet", {31'b0, protocol_err}, 32'd0);

        // Store then immediate load, address wrap
        store(16'h0103, 16'hA55A);
        dbg_chk("dbg_3", 16'h0003, 16'hA55A);
        dbg_chk("dbg_wrap_0703", 16'h0703, 16'hA55A);
        load(16'h0003, n, rx);
        chk("load3_nbytes", n, 2);
        chk("load3_bytes", rx, 32'h0000_A55A);
        store(16'h00FF, 16'h1234);
        load(16'hFFFF, n, rx);
        chk("load_ffff_bytes", rx, 32'h0000_1234);

        // Reset during the store write cycle must not write
        store(16'h0005, 16'h1111);
        bus_mar = 1'b1; bus_mdr = 1'b1; out_bus = 8'h05;
        @(negedge clk);
        bus_mar = 1'b0; bus_mdr = 1'b0; out_bus = 8'h00;
        @(negedge clk);
        out_bus = 8'h22;
        @(negedge clk);
        out_bus = 8'h22;
        rst = 1'b1;
        do_reset();
        dbg_chk("abort_store", 16'h0005, 16'h1111);
        chk("abort_store_idle", {31'b0, ard_receive_ready}, 32'd1);
        @(negedge clk);

        // ADD program driven by a minimal core model
        dut.imem_q[0] = 16'h1101; dut.imem_q[1] = 16'h0001;
        dut.imem_q[2] = 16'h2101; dut.imem_q[3] = 16'h0002;
        dut.imem_q[4] = 16'h3290;
        dut.imem_q[5] = 16'h0302; dut.imem_q[6] = 16'h0000;
        dut.imem_q[7] = 16'h0007;
        pc = 16'd0; r1 = '0; r2 = '0; sw_addr = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("add_pc%0d", i), {16'b0, pc}, {16'b0, exp_pc[i]});
            fetch(pc, 1'b0, -1, n, rx);
            chk($sformatf("add_nbytes%0d", i), n, exp_n[i]);
            if (i == 0) r1 = rx[31:16];
            if (i == 1) r2 = rx[31:16];
            if (i == 3) sw_addr = rx[31:16];
            pc = pc + 16'(n / 2);
        end
        store(sw_addr, r1 + r2);
        dbg_chk("add_result", 16'h0000, 16'h0003);

        // Protocol errors
        fetch(16'h0010, 1'b1, -1, n, rx);
        chk("both_fetch_bytes", rx, 32'h0000_1230);
        chk("both_perr", {31'b0, protocol_err}, 32'd1);
        do_reset();
        chk("perr_cleared", {31'b0, protocol_err}, 32'd0);
        @(negedge clk);
        fetch(16'h0020, 1'b0, 1, n, rx);
        chk("mar_in_ihi_nbytes", n, 4);
        chk("mar_in_ihi_bytes", rx, 32'hBEEF_5671);
        chk("mar_in_ihi_perr", {31'b0, protocol_err}, 32'd1);
        repeat (3) @(negedge clk);
        chk("perr_sticky", {31'b0, protocol_err}, 32'd1);

        // Reset mid-fetch
        bus_pc = 1'b1; out_bus = 8'h10;
        @(negedge clk);
        bus_pc = 1'b0; out_bus = 8'h00;
        @(negedge clk);
        @(negedge clk);
        chk("midfetch_drdy", {31'b0, ard_data_ready}, 32'd1);
        chk("midfetch_byte", {24'b0, in_bus}, 32'h0000_0030);
        rst = 1'b1;
        do_reset();
        chk("midrst_drdy", {31'b0, ard_data_ready}, 32'd0);
        chk("midrst_rrdy", {31'b0, ard_receive_ready}, 32'd1);
        chk("midrst_perr", {31'b0, protocol_err}, 32'd0);
        @(negedge clk);
        fetch(16'h0000, 1'b0, -1, n, rx);
        chk("after_rst_fetch_bytes", rx, 32'h0001_1101);

`ifdef SERIAL_MEM_TXN_COUNT_EN
        do_reset();
        chk("txn_reset", {16'b0, txn_count}, 32'd0);
        @(negedge clk);
        fetch(16'h0010, 1'b0, -1, n, rx);
        fetch(16'h0020, 1'b0, -1, n, rx);
        fetch(16'h0030, 1'b0, -1, n, rx);
        store(16'h0007, 16'h0077);
        load(16'h0007, n, rx);
        chk("txn_five", {16'b0, txn_count}, 32'd5);
        dut.txn_q = 16'hFFFF;
        fetch(16'h0010, 1'b0, -1, n, rx);
        chk("txn_wrap", {16'b0, txn_count}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
